// File: rtl/tlm_fifo_pkg.sv
// Shared constants and helpers for the transaction FIFO.
package tlm_fifo_pkg;

    localparam int DATA_W_DEF = 65;
    localparam int DEPTH_DEF  = 16;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tlm_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module tlm_fifo_mem
    import tlm_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately left unreset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tlm_fifo.sv
// First-word-fall-through valid/ready FIFO with occupancy count.
module tlm_fifo
    import tlm_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   put_valid,
    output logic                   put_ready,
    input  logic [DATA_W-1:0]      put_data,
    output logic                   get_valid,
    input  logic                   get_ready,
    output logic [DATA_W-1:0]      get_data,
    output logic [ptr_w(DEPTH):0]  count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          put_fire;
    logic          get_fire;

    // Flags come from the registered count only, so no ready/valid loops.
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign put_ready = !full;
    assign get_valid = !empty;
    assign put_fire  = put_valid && put_ready;
    assign get_fire  = get_valid && get_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (put_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (get_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({put_fire, get_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    tlm_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (put_fire),
        .wr_addr (wr_ptr),
        .wr_data (put_data),
        .rd_addr (rd_ptr),
        .rd_data (get_data)
    );

endmodule

// File: tb/tb_tlm_fifo.sv
// Directed and randomized checks of tlm_fifo against hand values and a queue.
module tb_tlm_fifo;

    logic        clk;
    logic        reset;
    logic        put_valid;
    logic        put_ready;
    logic [64:0] put_data;
    logic        get_valid;
    logic        get_ready;
    logic [64:0] get_data;
    logic [4:0]  count;
    logic        full;
    logic        empty;

    int tests = 0;
    int fails = 0;

    logic [64:0] q[$];
    logic [95:0] rnd;
    logic [64:0] word;
    logic        pf;
    logic        gf;

    tlm_fifo #(.DATA_W(65), .DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .put_valid (put_valid),
        .put_ready (put_ready),
        .put_data  (put_data),
        .get_valid (get_valid),
        .get_ready (get_ready),
        .get_data  (get_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] obs,
                       input logic [64:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        put_valid = 1'b0;
        put_data  = '0;
        get_ready = 1'b0;
        step();
        put_valid = 1'b1;
        put_data  = 65'h5;
        step();
        chk("rst_count", 65'(count), 65'd0);
        chk("rst_empty", 65'(empty), 65'd1);
        chk("rst_full", 65'(full), 65'd0);
        chk("rst_put_ready", 65'(put_ready), 65'd1);
        chk("rst_get_valid", 65'(get_valid), 65'd0);
        put_valid = 1'b0;
        reset     = 1'b1;
        step();
        chk("rst_no_xfer", 65'(count), 65'd0);

        // three words in, then drain in order
        put_valid = 1'b1;
        put_data  = 65'h1;
        step();
        put_data  = 65'h2;
        step();
        put_data  = 65'h3;
        step();
        put_valid = 1'b0;
        chk("p3_count", 65'(count), 65'd3);
        chk("p3_get_valid", 65'(get_valid), 65'd1);
        get_ready = 1'b1;
        chk("p3_d1", get_data, 65'h1);
        step();
        chk("p3_d2", get_data, 65'h2);
        step();
        chk("p3_d3", get_data, 65'h3);
        step();
        get_ready = 1'b0;
        chk("p3_empty", 65'(empty), 65'd1);
        chk("p3_count0", 65'(count), 65'd0);

        // fill to full, 17th word blocked
        put_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            put_data = 65'(100 + i);
            step();
        end
        chk("full_flag", 65'(full), 65'd1);
        chk("full_put_ready", 65'(put_ready), 65'd0);
        chk("full_count", 65'(count), 65'd16);
        put_data = 65'h1_0000_0000_0000_03E7;
        step();
        step();
        chk("full_blocked", 65'(count), 65'd16);
        chk("full_head", get_data, 65'd100);
        get_ready = 1'b1;
        step();
        get_ready = 1'b0;
        chk("full_get_cnt", 65'(count), 65'd15);
        chk("full_ready_back", 65'(put_ready), 65'd1);
        step();
        put_valid = 1'b0;
        chk("full_refill", 65'(count), 65'd16);
        get_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("full_drain", get_data, 65'(100 + i));
            step();
        end
        chk("full_last", get_data, 65'h1_0000_0000_0000_03E7);
        step();
        get_ready = 1'b0;
        chk("full_empty", 65'(empty), 65'd1);

        // streaming 40 words across pointer wrap
        put_valid = 1'b1;
        put_data  = 65'h1_0000_0000_0000_0A00;
        step();
        get_ready = 1'b1;
        for (int i = 1; i < 40; i++) begin
            put_data = 65'h1_0000_0000_0000_0A00 + 65'(i);
            chk("str_data", get_data, 65'h1_0000_0000_0000_0A00 + 65'(i - 1));
            step();
            chk("str_count", 65'(count), 65'd1);
        end
        put_valid = 1'b0;
        chk("str_last", get_data, 65'h1_0000_0000_0000_0A27);
        step();
        get_ready = 1'b0;
        chk("str_empty", 65'(empty), 65'd1);

        // mid-operation async reset
        put_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            put_data = 65'(200 + i);
            step();
        end
        put_valid = 1'b0;
        chk("ar_loaded", 65'(count), 65'd5);
        reset = 1'b0;
        #1;
        chk("ar_count", 65'(count), 65'd0);
        chk("ar_empty", 65'(empty), 65'd1);
        chk("ar_get_valid", 65'(get_valid), 65'd0);
        #1;
        reset = 1'b1;
        step();
        chk("ar_after", 65'(get_valid), 65'd0);
        put_valid = 1'b1;
        put_data  = 65'hABC;
        step();
        put_valid = 1'b0;
        chk("ar_fresh", get_data, 65'hABC);
        chk("ar_fresh_cnt", 65'(count), 65'd1);
        get_ready = 1'b1;
        step();
        get_ready = 1'b0;
        chk("ar_drained", 65'(empty), 65'd1);

        // random traffic against a queue model
        q.delete();
        for (int c = 0; c < 1000; c++) begin
            rnd       = {$urandom, $urandom, $urandom};
            word      = rnd[64:0];
            put_valid = ($urandom_range(1, 0) == 1);
            get_ready = ($urandom_range(1, 0) == 1);
            put_data  = word;
            chk("rnd_count", 65'(count), 65'(q.size()));
            chk("rnd_get_valid", 65'(get_valid), 65'(q.size() != 0));
            chk("rnd_put_ready", 65'(put_ready), 65'(q.size() < 16));
            chk("rnd_bound", 65'(count <= 5'd16), 65'd1);
            if (q.size() != 0) begin
                chk("rnd_data", get_data, q[0]);
            end
            pf = put_valid && (q.size() < 16);
            gf = get_ready && (q.size() != 0);
            if (gf) begin
                void'(q.pop_front());
            end
            if (pf) begin
                q.push_back(word);
            end
            step();
        end
        put_valid = 1'b0;
        get_ready = 1'b0;
        chk("rnd_final", 65'(count), 65'(q.size()));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tlm_fifo.md
TLM_FIFO -- requirements
Module: tlm_fifo

Interface
REQ-001 Parameter DATA_W, default 65, transaction payload width in bits.
REQ-002 Parameter DEPTH, default 16, number of entries; a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 put_valid  input  1  producer offers put_data this cycle.
REQ-006 put_ready  output  1  FIFO accepts an offered word this cycle.
REQ-007 put_data  input  DATA_W  payload written on put transfer.
REQ-008 get_valid  output  1  head entry present on get_data.
REQ-009 get_ready  input  1  consumer takes the head entry this cycle.
REQ-010 get_data  output  DATA_W  head entry, first-word-fall-through.
REQ-011 count  output  clog2(DEPTH)+1  number of stored entries.
REQ-012 full  output  1  count equals DEPTH.
REQ-013 empty  output  1  count equals 0.

Function
REQ-014 Put transfer occurs on a rising edge where put_valid and put_ready are both 1; get transfer likewise with get_valid and get_ready.
REQ-015 put_ready = !full, derived from registered state only, with no combinational path from get_ready.
REQ-016 get_valid = !empty; get_data = storage[read pointer], with no combinational path from put side.
REQ-017 Words leave in exact arrival order, bit-exact, no loss or duplication.
REQ-018 Latency: a word put into an empty FIFO at edge N is visible with get_valid=1 after edge N, i.e. available for get in cycle N+1.
REQ-019 Simultaneous put and get transfer: count unchanged; both pointers advance.
REQ-020 When full, put is refused (put_ready=0) even if get_ready=1 in the same cycle; the slot frees one cycle later.
REQ-021 When empty, get is refused (get_valid=0) even if put_valid=1 in the same cycle.
REQ-022 Read and write pointers are clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-023 count increments on put-only, decrements on get-only, and never exceeds DEPTH or goes below 0.
REQ-024 get_data holds stable while get_valid=1 and get_ready=0.
REQ-025 Producer holding put_valid with constant put_data while put_ready=0 loses nothing; the word is written when put_ready returns to 1.

Reset
REQ-026 reset=0 asynchronously clears both pointers and count: count=0, empty=1, full=0, put_ready=1, get_valid=0.
REQ-027 Storage contents are not reset; get_data is don't-care while empty.
REQ-028 Reset asserted mid-operation discards all stored entries; no transfer occurs on an edge while reset=0.

Structure
REQ-029 Package tlm_fifo_pkg holds the default DATA_W (65) and DEPTH (16) constants and the pointer-width function.
REQ-030 Storage array sits in one sub-module, tlm_fifo_mem: 1 write port, 1 asynchronous read port, no reset.
REQ-031 Pointer, count and flag logic resides in tlm_fifo itself.

Verification
REQ-032 After reset, put 0x1, 0x2, 0x3 with get_ready=0 -> count=3; then get_ready=1 -> get_data 0x1, 0x2, 0x3 in order, then empty=1.
REQ-033 Put 16 words with get_ready=0 -> full=1, put_ready=0, count=16; a 17th offered word is not accepted until one get occurs.
REQ-034 Full FIFO with put_valid=1 and get_ready=1 for 1 cycle -> count=15 after that edge; next cycle put accepted -> count=16.
REQ-035 Continuous put and get for 40 words (pointer wrap) -> output sequence equals input sequence, count steady at 1.
REQ-036 Load 5 words, pulse reset=0 between edges -> count=0 and empty=1 immediately; no stale word appears afterwards.
REQ-037 Random put_valid/get_ready at 50% for 1000 cycles against a queue model -> zero mismatches; count never exceeds 16.
